// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if: control/status bundle between a run controller and its host/CPU.
//   master : drives run/step/halt requests, step_count and cpu_halt; observes status.
//   slave  : the controller; observes requests, drives cpu_rst_n, cpu_ce, state,
//            cycle_cnt, halted_by_cpu and wdt_fired.
interface cpu_run_ctrl_if #(
  parameter int unsigned STEP_W = 8,
  parameter int unsigned CNT_W  = 32
) ();
  logic              run_req;
  logic              step_req;
  logic              halt_req;
  logic [STEP_W-1:0] step_count;
  logic              cpu_halt;
  logic              cpu_rst_n;
  logic              cpu_ce;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic              halted_by_cpu;
  logic              wdt_fired;

  modport master (
    output run_req, step_req, halt_req, step_count, cpu_halt,
    input  cpu_rst_n, cpu_ce, state, cycle_cnt, halted_by_cpu, wdt_fired
  );

  modport slave (
    input  run_req, step_req, halt_req, step_count, cpu_halt,
    output cpu_rst_n, cpu_ce, state, cycle_cnt, halted_by_cpu, wdt_fired
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequenced CPU reset, run/step/halt control through a clock enable,
// and a count of cycles the CPU was enabled.
//   clk      : system clock, rising edge
//   rst_n    : asynchronous active-low reset
//   ctrl_io  : cpu_run_ctrl_if.slave (requests in; cpu_rst_n, cpu_ce, state,
//              cycle_cnt, halted_by_cpu, wdt_fired out)
// Optional watchdog in RUN is built only when MIPS_CPU_WDT_EN is defined; otherwise
// wdt_fired is tied low and RUN continues until halted.
module cpu_run_ctrl #(
  parameter int unsigned RST_CYCLES = 4,
  parameter int unsigned STEP_W     = 8,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WDT_CYCLES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  cpu_run_ctrl_if.slave ctrl_io
);

  typedef enum logic [1:0] {
    StRstHold = 2'd0,
    StIdle    = 2'd1,
    StRun     = 2'd2,
    StStep    = 2'd3
  } state_e;

  localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RST_CYCLES - 1);

  state_e            state_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic [STEP_W-1:0] step_rem_q;
  logic [CNT_W-1:0]  cycle_cnt_q;
  logic              cpu_rst_n_q;
  logic              cpu_ce_q;
  logic              halted_by_cpu_q;

`ifdef MIPS_CPU_WDT_EN
  localparam int unsigned WdtW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
  localparam logic [WdtW-1:0] WdtLast = WdtW'(WDT_CYCLES - 1);
  logic [WdtW-1:0] wdt_cnt_q;
  logic            wdt_fired_q;
`else
  logic unused_wdt_cycles;
  assign unused_wdt_cycles = ^WDT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StRstHold;
      rst_cnt_q       <= '0;
      step_rem_q      <= '0;
      cycle_cnt_q     <= '0;
      cpu_rst_n_q     <= 1'b0;
      cpu_ce_q        <= 1'b0;
      halted_by_cpu_q <= 1'b0;
`ifdef MIPS_CPU_WDT_EN
      wdt_cnt_q       <= '0;
      wdt_fired_q     <= 1'b0;
`endif
    end else begin
      if (cpu_ce_q) begin
        cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      end

      unique case (state_q)
        StRstHold: begin
          // Requests are dropped here, not queued.
          if (rst_cnt_q == RstLast) begin
            cpu_rst_n_q <= 1'b1;
            state_q     <= StIdle;
          end else begin
            rst_cnt_q <= rst_cnt_q + RstW'(1);
          end
        end

        StIdle: begin
          // halt_req masks step_req, which masks run_req; a zero-length step is dropped.
          if (ctrl_io.halt_req) begin
            state_q <= StIdle;
          end else if (ctrl_io.step_req) begin
            if (ctrl_io.step_count != '0) begin
              state_q         <= StStep;
              cpu_ce_q        <= 1'b1;
              step_rem_q      <= ctrl_io.step_count;
              halted_by_cpu_q <= 1'b0;
`ifdef MIPS_CPU_WDT_EN
              wdt_fired_q     <= 1'b0;
`endif
            end
          end else if (ctrl_io.run_req) begin
            state_q         <= StRun;
            cpu_ce_q        <= 1'b1;
            halted_by_cpu_q <= 1'b0;
`ifdef MIPS_CPU_WDT_EN
            wdt_fired_q     <= 1'b0;
            wdt_cnt_q       <= '0;
`endif
          end
        end

        StRun: begin
          if (ctrl_io.halt_req || ctrl_io.cpu_halt) begin
            state_q  <= StIdle;
            cpu_ce_q <= 1'b0;
            if (ctrl_io.cpu_halt) begin
              halted_by_cpu_q <= 1'b1;
            end
`ifdef MIPS_CPU_WDT_EN
          end else if (wdt_cnt_q == WdtLast) begin
            // ce is high on every RUN cycle, so this is the WDT_CYCLES-th ce cycle.
            state_q     <= StIdle;
            cpu_ce_q    <= 1'b0;
            wdt_fired_q <= 1'b1;
          end else begin
            wdt_cnt_q <= wdt_cnt_q + WdtW'(1);
`endif
          end
        end

        StStep: begin
          if (ctrl_io.halt_req || ctrl_io.cpu_halt) begin
            state_q  <= StIdle;
            cpu_ce_q <= 1'b0;
            if (ctrl_io.cpu_halt) begin
              halted_by_cpu_q <= 1'b1;
            end
          end else if (step_rem_q == STEP_W'(1)) begin
            state_q  <= StIdle;
            cpu_ce_q <= 1'b0;
          end else begin
            step_rem_q <= step_rem_q - STEP_W'(1);
          end
        end
      endcase
    end
  end

  assign ctrl_io.cpu_rst_n     = cpu_rst_n_q;
  assign ctrl_io.cpu_ce        = cpu_ce_q;
  assign ctrl_io.state         = state_q;
  assign ctrl_io.cycle_cnt     = cycle_cnt_q;
  assign ctrl_io.halted_by_cpu = halted_by_cpu_q;
`ifdef MIPS_CPU_WDT_EN
  assign ctrl_io.wdt_fired     = wdt_fired_q;
`else
  assign ctrl_io.wdt_fired     = 1'b0;
`endif

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Parametrised successor to the bare CPU top wrapper. Sits between the top-level clk/rst_n pins and the CPU core, and replaces the wire-through with a sequenced CPU reset, run/step/halt control via a clock-enable, and a retired-cycle counter. The CPU revision paired with this block takes cpu_rst_n and cpu_ce and reports cpu_halt (break/syscall-halt) back.

Parameters:
RST_CYCLES, 4, cycles cpu_rst_n is held low after rst_n deasserts (>=1)
STEP_W, 8, width of step_count
CNT_W, 32, width of cycle_cnt
WDT_CYCLES, 1024, watchdog limit in RUN (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
run_req  in  1  pulse: enter free-run
step_req  in  1  pulse: execute step_count cycles then stop
halt_req  in  1  pulse: stop immediately
step_count  in  STEP_W  cycles per step, sampled on accepted step_req
cpu_halt  in  1  CPU self-halt indication
cpu_rst_n  out  1  reset to CPU core
cpu_ce  out  1  CPU clock enable
state  out  2  0=RST_HOLD 1=IDLE 2=RUN 3=STEP
cycle_cnt  out  CNT_W  count of cycles with cpu_ce=1
halted_by_cpu  out  1  sticky: last stop caused by cpu_halt
wdt_fired  out  1  sticky: watchdog stop (0 when feature disabled)

Behaviour:
- Reset (rst_n=0, async): state=RST_HOLD, cpu_rst_n=0, cpu_ce=0, cycle_cnt=0, halted_by_cpu=0, wdt_fired=0, internal counters 0.
- RST_HOLD: cpu_rst_n=0; counter increments each cycle after rst_n rises; after RST_CYCLES cycles at 0, cpu_rst_n registers to 1 and state -> IDLE. cpu_rst_n never goes low except via rst_n (asserts async, deasserts synchronously).
- IDLE: cpu_ce=0. Request priority in any state: halt_req > step_req > run_req.
  - run_req -> RUN next cycle; clears halted_by_cpu, wdt_fired.
  - step_req with step_count!=0 -> STEP, load step remaining=step_count; clears sticky flags. step_count=0: request ignored, stay IDLE.
- RUN: cpu_ce=1 (registered, first ce-high cycle is the cycle after entering). halt_req -> IDLE. cpu_halt=1 -> IDLE, set halted_by_cpu. step_req/run_req ignored.
- STEP: cpu_ce=1 exactly step_count cycles, remaining decrements per ce cycle; at remaining==1 with ce high, next state IDLE. halt_req or cpu_halt abort to IDLE (cpu_halt sets halted_by_cpu). run_req ignored.
- cpu_halt while in IDLE: no effect.
- Simultaneous halt_req and cpu_halt: IDLE, halted_by_cpu set.
- cycle_cnt: +1 per cycle with cpu_ce=1, wraps modulo 2^CNT_W (all-ones -> 0). Not cleared by run/step; only by rst_n.
- Output state transitions visible one cycle after the request edge; cpu_ce follows state combinationally-free (registered with state).
- Requests during RST_HOLD are ignored (not queued).

Optional Feature:
MIPS_CPU_WDT_EN: when defined, a counter runs in RUN, reset on entry to RUN and whenever cpu_halt... no: reset on entry only; on reaching WDT_CYCLES ce cycles, state -> IDLE and wdt_fired=1. Not active in STEP. When undefined, no watchdog logic; wdt_fired tied 0 and RUN continues indefinitely.

Test Plan:
- Release rst_n with RST_CYCLES=4 -> cpu_rst_n low exactly 4 cycles after release, state=IDLE, cpu_ce=0, cycle_cnt=0.
- step_req with step_count=5 -> cpu_ce high exactly 5 cycles, state returns to 1, cycle_cnt=5; step_count=0 -> no ce, state stays 1.
- run_req, then halt_req after 10 cycles -> cycle_cnt=10, state=1; same cycle step_req+halt_req -> stays IDLE.
- RUN then cpu_halt=1 -> IDLE next cycle, halted_by_cpu=1; subsequent run_req clears it.
- CNT_W=4, run 17 cycles -> cycle_cnt wraps to 1; assert rst_n mid-RUN -> cpu_rst_n and cpu_ce drop immediately, all outputs at reset values.
- With MIPS_CPU_WDT_EN, WDT_CYCLES=16: run_req with no halt -> stop after 16 ce cycles, wdt_fired=1; without macro -> still RUN at 100 cycles, wdt_fired=0.
